// File: rtl/power_pkg.sv
// Shared definitions for the board power sequencer: state encoding, fault
// counter width and default timing constants at 50 MHz.
package power_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_MONITOR   = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_FAULT     = 3'd4,
    ST_LOCKOUT   = 3'd5
  } state_t;

  localparam int FAULT_CNT_W    = 4;
  localparam int STEP_DELAY_1MS = 50000;
  localparam int COOLDOWN_10MS  = 500000;

  function automatic logic [FAULT_CNT_W-1:0] sat_inc(input logic [FAULT_CNT_W-1:0] value);
    logic [FAULT_CNT_W-1:0] result;
    if (value == {FAULT_CNT_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + FAULT_CNT_W'(1);
    end
    return result;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/power_step_timer.sv
// Loadable down-counter shared by the rail-step and fault-cooldown paths.
// done is high while the count sits at zero; a fresh load restarts the interval.
module power_step_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count_r;

  // Count down to zero and hold there until the next load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {WIDTH{1'b0}}) begin
      count_r <= count_r - WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/power_sequencer.sv
// Orders rail enables on/off, owns power_management start, and handles fault
// shutdown, cooldown, bounded retry and lockout.
module power_sequencer
  import power_pkg::*;
#(
  parameter int NUM_RAILS  = 4,
  parameter int STEP_DELAY = STEP_DELAY_1MS,
  parameter int COOLDOWN   = COOLDOWN_10MS,
  parameter int RETRY_MAX  = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable_req,
  input  logic                   clear_lockout,
  input  logic                   pm_error,
  output logic                   pm_start,
  output logic [NUM_RAILS-1:0]   rail_en,
  output logic                   power_good,
  output logic                   locked_out,
  output logic [FAULT_CNT_W-1:0] fault_count,
  output logic [2:0]             state_dbg
);

  localparam int TIMER_W = $clog2(max_int(STEP_DELAY, COOLDOWN));
  localparam int IDX_W   = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;

  localparam logic [TIMER_W-1:0]     STEP_LOAD = TIMER_W'(STEP_DELAY - 1);
  localparam logic [TIMER_W-1:0]     COOL_LOAD = TIMER_W'(COOLDOWN - 1);
  localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NUM_RAILS - 1);
  localparam logic [NUM_RAILS-1:0]   RAIL_ONE  = NUM_RAILS'(1);
  localparam logic [FAULT_CNT_W-1:0] RETRY_LIM = FAULT_CNT_W'(RETRY_MAX);

  state_t                 state_r;
  state_t                 state_s;
  logic [IDX_W-1:0]       index_r;
  logic [IDX_W-1:0]       index_s;
  logic [NUM_RAILS-1:0]   rail_en_s;
  logic [FAULT_CNT_W-1:0] fault_count_s;
  logic                   timer_load_s;
  logic [TIMER_W-1:0]     timer_val_s;
  logic                   timer_done_s;

  power_step_timer #(
    .WIDTH (TIMER_W)
  ) u_step_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .done     (timer_done_s)
  );

  // Next state, rail pattern, rail index and fault count
  always_comb begin
    state_s       = state_r;
    index_s       = index_r;
    rail_en_s     = rail_en;
    fault_count_s = fault_count;
    case (state_r)
      ST_OFF: begin
        if (enable_req) begin
          state_s   = ST_RAMP_UP;
          index_s   = {IDX_W{1'b0}};
          rail_en_s = RAIL_ONE;
        end else begin
          fault_count_s = {FAULT_CNT_W{1'b0}};
        end
      end
      ST_RAMP_UP: begin
        if (!enable_req) begin
          state_s = ST_RAMP_DOWN;
        end else if (timer_done_s) begin
          if (index_r == LAST_IDX) begin
            state_s = ST_MONITOR;
          end else begin
            index_s   = index_r + IDX_W'(1);
            rail_en_s = rail_en | (RAIL_ONE << (index_r + IDX_W'(1)));
          end
        end else begin
          state_s = ST_RAMP_UP;
        end
      end
      ST_MONITOR: begin
        // A fault outranks a simultaneous power-off request
        if (pm_error) begin
          state_s       = ST_FAULT;
          rail_en_s     = {NUM_RAILS{1'b0}};
          fault_count_s = sat_inc(fault_count);
        end else if (!enable_req) begin
          state_s = ST_RAMP_DOWN;
        end else begin
          state_s = ST_MONITOR;
        end
      end
      ST_RAMP_DOWN: begin
        if (timer_done_s) begin
          rail_en_s = rail_en & ~(RAIL_ONE << index_r);
          if (index_r == {IDX_W{1'b0}}) begin
            state_s = ST_OFF;
          end else begin
            index_s = index_r - IDX_W'(1);
          end
        end else begin
          state_s = ST_RAMP_DOWN;
        end
      end
      ST_FAULT: begin
        rail_en_s = {NUM_RAILS{1'b0}};
        if (timer_done_s) begin
          if (fault_count >= RETRY_LIM) begin
            state_s = ST_LOCKOUT;
          end else if (enable_req) begin
            state_s   = ST_RAMP_UP;
            index_s   = {IDX_W{1'b0}};
            rail_en_s = RAIL_ONE;
          end else begin
            state_s = ST_OFF;
            index_s = {IDX_W{1'b0}};
          end
        end else begin
          state_s = ST_FAULT;
        end
      end
      ST_LOCKOUT: begin
        rail_en_s = {NUM_RAILS{1'b0}};
        if (clear_lockout) begin
          state_s       = ST_OFF;
          index_s       = {IDX_W{1'b0}};
          fault_count_s = {FAULT_CNT_W{1'b0}};
        end else begin
          state_s = ST_LOCKOUT;
        end
      end
      default: begin
        state_s   = ST_OFF;
        index_s   = {IDX_W{1'b0}};
        rail_en_s = {NUM_RAILS{1'b0}};
      end
    endcase
  end

  // Restart the interval timer on every state or rail-index change
  always_comb begin
    timer_load_s = (state_s != state_r) || (index_s != index_r);
    if (state_s == ST_FAULT) begin
      timer_val_s = COOL_LOAD;
    end else begin
      timer_val_s = STEP_LOAD;
    end
  end

  // State and registered outputs; reset drops every rail at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_OFF;
      index_r     <= {IDX_W{1'b0}};
      rail_en     <= {NUM_RAILS{1'b0}};
      fault_count <= {FAULT_CNT_W{1'b0}};
      pm_start    <= 1'b0;
      power_good  <= 1'b0;
      locked_out  <= 1'b0;
    end else begin
      state_r     <= state_s;
      index_r     <= index_s;
      rail_en     <= rail_en_s;
      fault_count <= fault_count_s;
      pm_start    <= (state_s == ST_MONITOR);
      power_good  <= (state_s == ST_MONITOR);
      locked_out  <= (state_s == ST_LOCKOUT);
    end
  end

  assign state_dbg = state_r;

endmodule

// File: tb/tb_power_sequencer.sv
// Directed bench for power_sequencer with short timing (3 rails, step 4,
// cooldown 8, two faults to lockout); outputs are sampled on the falling edge.
module tb_power_sequencer;

  logic       clk;
  logic       reset_n;
  logic       enable_req;
  logic       clear_lockout;
  logic       pm_error;
  logic       pm_start;
  logic [2:0] rail_en;
  logic       power_good;
  logic       locked_out;
  logic [3:0] fault_count;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  power_sequencer #(
    .NUM_RAILS  (3),
    .STEP_DELAY (4),
    .COOLDOWN   (8),
    .RETRY_MAX  (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable_req    (enable_req),
    .clear_lockout (clear_lockout),
    .pm_error      (pm_error),
    .pm_start      (pm_start),
    .rail_en       (rail_en),
    .power_good    (power_good),
    .locked_out    (locked_out),
    .fault_count   (fault_count),
    .state_dbg     (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    enable_req    = 1'b0;
    clear_lockout = 1'b0;
    pm_error      = 1'b0;
    tick(2);
    check("reset_rail", 32'(rail_en), 32'h0);
    check("reset_start", 32'(pm_start), 32'h0);
    check("reset_pg", 32'(power_good), 32'h0);
    check("reset_lock", 32'(locked_out), 32'h0);
    check("reset_fcnt", 32'(fault_count), 32'h0);
    check("reset_state", 32'(state_dbg), 32'h0);
    reset_n = 1'b1;
    tick(1);

    // Power-up: cycle 0 is this falling edge
    enable_req = 1'b1;
    tick(1);
    check("up_c1_rail", 32'(rail_en), 32'h1);
    check("up_c1_state", 32'(state_dbg), 32'h1);
    tick(3);
    check("up_c4_rail", 32'(rail_en), 32'h1);
    tick(1);
    check("up_c5_rail", 32'(rail_en), 32'h3);
    pm_error = 1'b1;
    tick(1);
    pm_error = 1'b0;
    check("up_err_ignored_state", 32'(state_dbg), 32'h1);
    check("up_err_ignored_fcnt", 32'(fault_count), 32'h0);
    tick(3);
    check("up_c9_rail", 32'(rail_en), 32'h7);
    tick(3);
    check("up_c12_start", 32'(pm_start), 32'h0);
    tick(1);
    check("up_c13_start", 32'(pm_start), 32'h1);
    check("up_c13_pg", 32'(power_good), 32'h1);
    check("up_c13_state", 32'(state_dbg), 32'h2);
    clear_lockout = 1'b1;
    tick(1);
    clear_lockout = 1'b0;
    check("clear_ignored_state", 32'(state_dbg), 32'h2);
    tick(1);

    // Power-down from MONITOR
    enable_req = 1'b0;
    tick(1);
    check("dn_t1_start", 32'(pm_start), 32'h0);
    check("dn_t1_pg", 32'(power_good), 32'h0);
    check("dn_t1_state", 32'(state_dbg), 32'h3);
    check("dn_t1_rail", 32'(rail_en), 32'h7);
    tick(3);
    check("dn_t4_rail", 32'(rail_en), 32'h7);
    tick(1);
    check("dn_t5_rail", 32'(rail_en), 32'h3);
    tick(4);
    check("dn_t9_rail", 32'(rail_en), 32'h1);
    tick(4);
    check("dn_t13_rail", 32'(rail_en), 32'h0);
    check("dn_t13_state", 32'(state_dbg), 32'h0);

    // Fault and retry
    enable_req = 1'b1;
    tick(13);
    check("f1_pg", 32'(power_good), 32'h1);
    pm_error = 1'b1;
    tick(1);
    pm_error = 1'b0;
    check("f1_t1_rail", 32'(rail_en), 32'h0);
    check("f1_t1_start", 32'(pm_start), 32'h0);
    check("f1_t1_fcnt", 32'(fault_count), 32'h1);
    check("f1_t1_state", 32'(state_dbg), 32'h4);
    tick(7);
    check("f1_t8_state", 32'(state_dbg), 32'h4);
    tick(1);
    check("f1_t9_state", 32'(state_dbg), 32'h1);
    check("f1_t9_rail", 32'(rail_en), 32'h1);

    // Second fault leads to lockout
    tick(12);
    check("f2_pg", 32'(power_good), 32'h1);
    pm_error = 1'b1;
    tick(1);
    pm_error = 1'b0;
    check("f2_fcnt", 32'(fault_count), 32'h2);
    check("f2_state", 32'(state_dbg), 32'h4);
    tick(8);
    check("lock_state", 32'(state_dbg), 32'h5);
    check("lock_flag", 32'(locked_out), 32'h1);
    tick(5);
    check("lock_hold_rail", 32'(rail_en), 32'h0);
    check("lock_hold_flag", 32'(locked_out), 32'h1);
    clear_lockout = 1'b1;
    tick(1);
    clear_lockout = 1'b0;
    check("clr_state", 32'(state_dbg), 32'h0);
    check("clr_fcnt", 32'(fault_count), 32'h0);
    check("clr_flag", 32'(locked_out), 32'h0);
    check("clr_rail", 32'(rail_en), 32'h0);
    tick(1);
    check("reramp_state", 32'(state_dbg), 32'h1);
    check("reramp_rail", 32'(rail_en), 32'h1);

    // Abort ramp while two rails are on
    tick(4);
    check("ab_rail_pre", 32'(rail_en), 32'h3);
    enable_req = 1'b0;
    tick(1);
    check("ab_c1_state", 32'(state_dbg), 32'h3);
    check("ab_c1_rail", 32'(rail_en), 32'h3);
    tick(3);
    check("ab_c4_rail", 32'(rail_en), 32'h3);
    tick(1);
    check("ab_c5_rail", 32'(rail_en), 32'h1);
    check("ab_c5_start", 32'(pm_start), 32'h0);
    tick(4);
    check("ab_c9_rail", 32'(rail_en), 32'h0);
    check("ab_c9_state", 32'(state_dbg), 32'h0);
    check("ab_c9_start", 32'(pm_start), 32'h0);

    // Fault outranks power-off; cooldown with enable low returns to OFF
    enable_req = 1'b1;
    tick(13);
    check("f3_pg", 32'(power_good), 32'h1);
    pm_error   = 1'b1;
    enable_req = 1'b0;
    tick(1);
    pm_error = 1'b0;
    check("f3_state", 32'(state_dbg), 32'h4);
    check("f3_fcnt", 32'(fault_count), 32'h1);
    tick(8);
    check("f3_off_state", 32'(state_dbg), 32'h0);
    tick(1);
    check("f3_off_fcnt", 32'(fault_count), 32'h0);

    // Asynchronous reset in MONITOR
    enable_req = 1'b1;
    tick(13);
    check("ar_pg_before", 32'(power_good), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_rail", 32'(rail_en), 32'h0);
    check("ar_start", 32'(pm_start), 32'h0);
    check("ar_pg", 32'(power_good), 32'h0);
    check("ar_state", 32'(state_dbg), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/power_sequencer.md
Name: power_sequencer

Overview:
Sequences board power rails on and off in a fixed order and owns the `start` input of `power_management`. It reacts to `error` from `power_management` with an immediate shutdown, a cooldown and a bounded retry. After `RETRY_MAX` faults it locks out until software clears it. It sits between the SOPC control register (enable/clear) and `power_management` plus the rail enable pins.

Parameters:
- `NUM_RAILS`, 4, number of rail enables; rail 0 turns on first and off last.
- `STEP_DELAY`, 50000, cycles between consecutive rail transitions (1 ms at 50 MHz); must be ≥2.
- `COOLDOWN`, 500000, cycles all-off after a fault before a retry (10 ms); must be ≥2.
- `RETRY_MAX`, 3, faults tolerated before lockout; must be 1..15.

Ports:
- `clk` in 1: 50 MHz system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `enable_req` in 1: level; 1 requests power on, 0 requests power off.
- `clear_lockout` in 1: single-cycle pulse; leaves LOCKOUT.
- `pm_error` in 1: `error` from `power_management`.
- `pm_start` out 1: drives `start` of `power_management`.
- `rail_en` out NUM_RAILS: per-rail enable, 1 = on.
- `power_good` out 1: high only in MONITOR.
- `locked_out` out 1: high only in LOCKOUT.
- `fault_count` out 4: faults since the last clean off or clear.
- `state_dbg` out 3: encoded state for the status register.

Behaviour:
- Reset (async assert, sync release): state OFF; all outputs 0; internal timer and rail index 0.
- All outputs are registered.
- Timer: counter of width clog2(max(STEP_DELAY, COOLDOWN)); cleared on every state or rail-index change.
- States and encoding: OFF=0, RAMP_UP=1, MONITOR=2, RAMP_DOWN=3, FAULT=4, LOCKOUT=5.
- OFF:
  - `enable_req`=1 → next cycle RAMP_UP, `rail_en`[0]=1, index=0.
  - `fault_count` is cleared whenever in OFF with `enable_req`=0.
- RAMP_UP:
  - When timer==STEP_DELAY-1 and index<NUM_RAILS-1: index++, set `rail_en`[index].
  - When timer==STEP_DELAY-1 and index==NUM_RAILS-1: go to MONITOR; `pm_start`=1 and `power_good`=1 from the next cycle.
  - `enable_req`=0 → RAMP_DOWN from the current index.
  - `pm_error` is ignored (`pm_start` is low).
- MONITOR:
  - `pm_error`=1 → FAULT. Fault takes priority over `enable_req`=0 in the same cycle.
  - `enable_req`=0 → RAMP_DOWN; `pm_start` and `power_good` drop on entry.
- RAMP_DOWN:
  - On entry, `rail_en`[index] stays on for STEP_DELAY cycles.
  - Each STEP_DELAY: clear `rail_en`[index], index--.
  - After clearing rail 0 → OFF.
  - `enable_req`=1 mid ramp-down is ignored until OFF is reached.
- FAULT:
  - Entry cycle: `rail_en`=0 (all rails at once), `pm_start`=0, `power_good`=0.
  - `fault_count` increments, saturating at 15.
  - Dropping `pm_start` clears the `power_management` error latch.
  - Wait COOLDOWN cycles, then:
    - if `fault_count`≥RETRY_MAX → LOCKOUT;
    - else if `enable_req`=1 → RAMP_UP (same entry as from OFF);
    - else → OFF.
- LOCKOUT:
  - All rails off; `locked_out`=1.
  - `clear_lockout`=1 → OFF, `fault_count`=0, regardless of `enable_req`.
- `clear_lockout` has no effect outside LOCKOUT.
- Reset mid-operation: all rails drop asynchronously; no sequenced power-down.

Decomposition:
- Shared package `power_pkg`:
  - state encoding constants;
  - `FAULT_CNT_W`=4;
  - default timing constants (`STEP_DELAY_1MS`, `COOLDOWN_10MS`), shared with `power_management` grace values.
- One natural sub-module: `power_step_timer`.
  - Loadable down-counter with a done pulse.
  - Shared by the ramp and cooldown paths.

Test Plan (NUM_RAILS=3, STEP_DELAY=4, COOLDOWN=8, RETRY_MAX=2):
- Power-up: `enable_req` 0→1 at cycle 0.
  - `rail_en`=001 at cycle 1, 011 at 5, 111 at 9.
  - `pm_start`=1 and `power_good`=1 at cycle 13.
- Power-down from MONITOR: `enable_req`→0 at cycle t.
  - `pm_start`=0 at t+1.
  - `rail_en` 111→011 at t+5, 001 at t+9, 000 at t+13.
  - `state_dbg`=0 at t+13.
- Fault and retry: `pm_error` pulse in MONITOR at cycle t.
  - At t+1: `rail_en`=000, `pm_start`=0, `fault_count`=1.
  - At t+9: RAMP_UP with `rail_en`=001.
- Lockout: second fault after the retry.
  - `fault_count`=2; after cooldown `locked_out`=1.
  - `enable_req` held high keeps rails at 0.
  - `clear_lockout` pulse → next cycle OFF, `fault_count`=0; rails re-ramp one cycle later.
- Abort ramp: `enable_req` drops while `rail_en`=011.
  - `rail_en` goes to 001 after 4 cycles, then 000 after 4 more.
  - `pm_start` never rises.
- Async reset: assert `reset_n`=0 mid-MONITOR with no clock edge.
  - `rail_en`=000, `pm_start`=0, `power_good`=0 immediately.
